// File: rtl/bf16_cvt_arbiter.sv
`default_nettype none
// =============================================================================
// bf16_cvt_arbiter: round-robin front end sharing one FP32->BF16 converter.
// Revision 1.0
// =============================================================================
module bf16_cvt_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_operand,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2:0]           rsp_id,
  output logic [15:0]          rsp_result,
  output logic [3:0]           rsp_fpcsr,
  output logic                 cvt_enable,
  output logic [31:0]          cvt_operand,
  input  logic [15:0]          cvt_result,
  input  logic [3:0]           cvt_fpcsr,
  output logic [3:0]           flags_sticky,
  input  logic                 flags_clear,
  output logic                 busy,
  output logic [15:0]          op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  ptr;
  logic [2:0]  win;
  logic        win_found;
  logic        accept;
  logic        handshake;
  logic [31:0] win_operand;
  int          idx;

  // Round-robin search: first asserted request at or above ptr, wrapping.
  always_comb begin
    win       = 3'd0;
    win_found = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!win_found && 1'(req_valid >> idx)) begin
        win       = 3'(idx);
        win_found = 1'b1;
      end
    end
  end

  assign accept      = (state == IDLE) && win_found && !reset;
  assign req_ready   = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;
  assign win_operand = 32'(req_operand >> (32 * win));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cvt_enable = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        cvt_enable = 1'b1;
        state_nxt  = CAPT;
      end
      CAPT: begin
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign handshake = rsp_valid & rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= 3'd0;
      rsp_id       <= 3'd0;
      rsp_result   <= 16'd0;
      rsp_fpcsr    <= 4'd0;
      cvt_operand  <= 32'd0;
      flags_sticky <= 4'd0;
      op_count     <= 16'd0;
    end else begin
      op_count <= op_count + 16'(handshake);
      if (accept) begin
        cvt_operand <= win_operand;
        rsp_id      <= win;
        ptr         <= (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
      end
      // A clear coinciding with capture keeps this op's flags.
      if (state == CAPT) begin
        rsp_result   <= cvt_result;
        rsp_fpcsr    <= cvt_fpcsr;
        flags_sticky <= flags_clear ? cvt_fpcsr : (flags_sticky | cvt_fpcsr);
      end else if (flags_clear) begin
        flags_sticky <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bf16_cvt_arbiter.sv
`default_nettype none
// Bench for bf16_cvt_arbiter: directed vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level model.
module tb_bf16_cvt_arbiter;
  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_operand;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2:0]          rsp_id;
  logic [15:0]         rsp_result;
  logic [3:0]          rsp_fpcsr;
  logic                cvt_enable;
  logic [31:0]         cvt_operand;
  logic [15:0]         cvt_result;
  logic [3:0]          cvt_fpcsr;
  logic [3:0]          flags_sticky;
  logic                flags_clear;
  logic                busy;
  logic [15:0]         op_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count;

  typedef struct {
    int          idx;
    logic [31:0] op;
    bit          clr_capt;
    bit          clr_after;
    logic [15:0] res;
    logic [3:0]  fl;
    logic [3:0]  sticky;
  } vec_t;

  bf16_cvt_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_operand(req_operand),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_fpcsr(rsp_fpcsr),
    .cvt_enable(cvt_enable), .cvt_operand(cvt_operand), .cvt_result(cvt_result),
    .cvt_fpcsr(cvt_fpcsr), .flags_sticky(flags_sticky), .flags_clear(flags_clear),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Converter stand-in: truncating FP32->BF16, NaN raises bit 3, lost bits raise bit 0.
  function automatic logic [15:0] ref_res(input logic [31:0] x);
    return x[31:16];
  endfunction

  function automatic logic [3:0] ref_fl(input logic [31:0] x);
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return 4'b1000;
    if (x[15:0] != 16'd0) return 4'b0001;
    return 4'b0000;
  endfunction

  // One-cycle latency; garbage whenever not enabled so mistimed capture shows up.
  always @(posedge clk) begin
    if (cvt_enable) begin
      cvt_result <= ref_res(cvt_operand);
      cvt_fpcsr  <= ref_fl(cvt_operand);
    end else begin
      cvt_result <= 16'($urandom);
      cvt_fpcsr  <= 4'($urandom);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    check({tag, "_rsp_result"}, 32'(rsp_result), 0);
    check({tag, "_rsp_fpcsr"}, 32'(rsp_fpcsr), 0);
    check({tag, "_cvt_enable"}, 32'(cvt_enable), 0);
    check({tag, "_cvt_operand"}, cvt_operand, 0);
    check({tag, "_flags"}, 32'(flags_sticky), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_op_count"}, 32'(op_count), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = '0; flags_clear = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_count = 16'd0;
  endtask

  // Single op from idle with rsp_ready=1; checks the T..T+4 timeline.
  task automatic run_op(input vec_t v);
    @(posedge clk); #1;
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    req_operand[32*v.idx +: 32] = v.op;
    rsp_ready = 1'b1;
    #1 check("op_grant", 32'(req_ready), 32'(1 << v.idx));
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    check("op_cvt_enable", 32'(cvt_enable), 1);
    check("op_cvt_operand", cvt_operand, v.op);
    @(posedge clk); #1;
    flags_clear = v.clr_capt;
    #1;
    check("op_capt_enable", 32'(cvt_enable), 0);
    check("op_capt_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    flags_clear = 1'b0;
    #1;
    check("op_rsp_valid", 32'(rsp_valid), 1);
    check("op_rsp_id", 32'(rsp_id), 32'(v.idx));
    check("op_rsp_result", 32'(rsp_result), 32'(v.res));
    check("op_rsp_fpcsr", 32'(rsp_fpcsr), 32'(v.fl));
    check("op_flags", 32'(flags_sticky), 32'(v.sticky));
    exp_count++;
    @(posedge clk); #2;
    check("op_done_valid", 32'(rsp_valid), 0);
    check("op_done_busy", 32'(busy), 0);
    check("op_count", 32'(op_count), 32'(exp_count));
    if (v.clr_after) begin
      @(posedge clk); #1 flags_clear = 1'b1;
      @(posedge clk); #1 flags_clear = 1'b0;
      #1 check("flags_cleared", 32'(flags_sticky), 0);
    end
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 3))
      0: x[30:23] = 8'hFF;
      1: x[15:0] = 16'd0;
      default: ;
    endcase
    return x;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  bit          pend[NREQ];
  logic [31:0] pop[NREQ];

  initial begin
    vec_t        vecs[6];
    vec_t        wv;
    int          got[$];
    int          exp_order[5];
    int          n;
    int          w;
    int          mptr;
    bit          have_op;
    int          t_acc;
    int          op_id;
    logic [31:0] op_val;
    logic [3:0]  mflags;
    logic [NREQ-1:0] exp_ready;
    bit          exp_rv;

    vecs[0] = '{2, 32'h3F800000, 1'b0, 1'b0, 16'h3F80, 4'h0, 4'h0};
    vecs[1] = '{0, 32'h7FC00001, 1'b0, 1'b0, 16'h7FC0, 4'h8, 4'h8};
    vecs[2] = '{1, 32'h7F800000, 1'b0, 1'b1, 16'h7F80, 4'h0, 4'h8};
    vecs[3] = '{3, 32'h3F808001, 1'b0, 1'b0, 16'h3F80, 4'h1, 4'h1};
    vecs[4] = '{2, 32'h7FC00000, 1'b1, 1'b0, 16'h7FC0, 4'h8, 4'h8};
    vecs[5] = '{1, 32'h40490FDB, 1'b0, 1'b0, 16'h4049, 4'h1, 4'h9};
    exp_order = '{0, 1, 2, 3, 0};

    // Reset with requests pending: everything must read zero.
    reset = 1'b1; req_valid = '1; req_operand = '0; rsp_ready = 1'b1; flags_clear = 1'b0;
    exp_count = 16'd0;
    #23 check_zero("reset");
    @(posedge clk); #1 req_valid = '0; reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Round-robin with all requesters held valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) req_operand[32*i +: 32] = 32'h3F800000 + 32'(i << 16);
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && got.size() < 5; c++) begin
      #1;
      check("rr_onehot", 32'($onehot0(req_ready)), 1);
      if (req_ready != '0) got.push_back($clog2(req_ready));
      @(posedge clk); #1;
    end
    check("rr_count", got.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got.size()) check("rr_order", got[i], exp_order[i]);

    // Backpressure: five stalled cycles in RESP.
    do_reset();
    req_valid = 4'b0010;
    req_operand[63:32] = 32'h7FC00123;
    rsp_ready = 1'b0;
    #1 check("bp_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_operand[31:0] = 32'h3F800000;
    @(posedge clk);
    @(posedge clk); #2;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_id", 32'(rsp_id), 1);
      check("bp_result", 32'(rsp_result), 32'h7FC0);
      check("bp_fpcsr", 32'(rsp_fpcsr), 32'h8);
      check("bp_ready_low", 32'(req_ready), 0);
      check("bp_count", 32'(op_count), 0);
      @(posedge clk); #2;
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_valid", 32'(rsp_valid), 1);
    check("bp_hs_ready_low", 32'(req_ready), 0);
    check("bp_hs_count", 32'(op_count), 0);
    exp_count = 16'd1;
    @(posedge clk); #2;
    check("bp_after_count", 32'(op_count), 32'(exp_count));
    check("bp_after_valid", 32'(rsp_valid), 0);
    check("bp_next_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = '0;
    n = 0;
    while (busy && n < 10) begin @(posedge clk); #2; n++; end
    check("bp_drain", 32'(busy), 0);
    exp_count = 16'd2;
    check("bp_drain_count", 32'(op_count), 32'(exp_count));

    // Reset asserted during ISSUE.
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_operand[95:64] = 32'h40490FDB;
    #1 check("rm_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = 4'b1010;
    req_operand[63:32] = 32'h3F810000;
    #1;
    check("rm_issue", 32'(cvt_enable), 1);
    #2 reset = 1'b1;
    #1 check_zero("rm_async");
    @(posedge clk); #2 check("rm_no_rsp", 32'(rsp_valid), 0);
    @(posedge clk); #2 check("rm_no_rsp2", 32'(rsp_valid), 0);
    @(posedge clk); #1 reset = 1'b0; exp_count = 16'd0;
    #1 check("rm_first_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid = '0;
    n = 1;
    #1;
    while (!rsp_valid && n < 10) begin @(posedge clk); #2; n++; end
    check("rm_latency", n, 3);
    check("rm_rsp_id", 32'(rsp_id), 1);
    check("rm_rsp_result", 32'(rsp_result), 32'h3F81);
    exp_count++;
    @(posedge clk); #2;
    check("rm_count", 32'(op_count), 32'(exp_count));
    check("rm_idle", 32'(busy), 0);

    // op_count wrap: preload near the top, then two handshakes.
    @(posedge clk); #1 force dut.op_count = 16'hFFFE;
    @(posedge clk); #1 release dut.op_count;
    exp_count = 16'hFFFE;
    #1 check("wrap_preload", 32'(op_count), 32'hFFFE);
    wv = '{0, 32'h3F800000, 1'b0, 1'b0, 16'h3F80, 4'h0, 4'h0};
    run_op(wv);
    run_op(wv);
    check("wrap_zero", 32'(op_count), 0);

    // Randomized traffic against a transaction-level model.
    do_reset();
    mptr = 0; have_op = 1'b0; t_acc = 0; op_id = 0; op_val = '0; mflags = 4'd0;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; pop[i] = '0; end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pop[i] = rand_operand();
        end
        req_valid[i] = pend[i];
        req_operand[32*i +: 32] = pop[i];
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      flags_clear = ($urandom_range(0, 7) == 0);
      #1;
      w = -1;
      if (!have_op)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && pend[(mptr + k) % NREQ]) w = (mptr + k) % NREQ;
      exp_ready = (w >= 0) ? NREQ'(1 << w) : '0;
      exp_rv = have_op && (cyc >= t_acc + 3);
      check("rnd_req_ready", 32'(req_ready), 32'(exp_ready));
      check("rnd_cvt_enable", 32'(cvt_enable), 32'(have_op && cyc == t_acc + 1));
      if (have_op && cyc == t_acc + 1) check("rnd_cvt_operand", cvt_operand, op_val);
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        check("rnd_rsp_id", 32'(rsp_id), 32'(op_id));
        check("rnd_rsp_result", 32'(rsp_result), 32'(ref_res(op_val)));
        check("rnd_rsp_fpcsr", 32'(rsp_fpcsr), 32'(ref_fl(op_val)));
      end
      check("rnd_flags", 32'(flags_sticky), 32'(mflags));
      check("rnd_op_count", 32'(op_count), 32'(exp_count));
      if (have_op && cyc == t_acc + 2)
        mflags = flags_clear ? ref_fl(op_val) : (mflags | ref_fl(op_val));
      else if (flags_clear)
        mflags = 4'd0;
      if (exp_rv && rsp_ready) begin
        exp_count++;
        have_op = 1'b0;
      end else if (w >= 0) begin
        have_op = 1'b1;
        t_acc = cyc;
        op_id = w;
        op_val = pop[w];
        pend[w] = 1'b0;
        mptr = (w + 1) % NREQ;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bf16_cvt_arbiter.md
BF16_CVT_ARBITER -- requirements
Module: bf16_cvt_arbiter

Interface
REQ-001 The module SHALL have one parameter: NREQ, default 4, number of requesters sharing one FP32->BF16 converter (2..8).
REQ-002 The module SHALL use one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-003 The module SHALL have these ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- req_valid  in  NREQ  per-requester request
- req_operand  in  NREQ*32  FP32 operand; slice i = bits [32i+31:32i]
- req_ready  out  NREQ  one-hot accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  3  requester index of response
- rsp_result  out  16  BF16 result
- rsp_fpcsr  out  4  converter flags for this op
- cvt_enable  out  1  to converter instruction_enable
- cvt_operand  out  32  to converter operand_a
- cvt_result  in  16  from converter result
- cvt_fpcsr  in  4  from converter fpcsr
- flags_sticky  out  4  OR-accumulated fpcsr
- flags_clear  in  1  clears flags_sticky
- busy  out  1  high in any state except IDLE
- op_count  out  16  completed-response counter

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, CAPT and RESP.
- IDLE->ISSUE on accept.
- ISSUE->CAPT unconditionally.
- CAPT->RESP unconditionally.
- RESP->IDLE on rsp_valid&rsp_ready.
REQ-005 In IDLE, req_ready SHALL be combinationally one-hot to the round-robin winner among asserted req_valid bits; all zero otherwise.
- Search starts at pointer ptr and ascends modulo NREQ.
REQ-006 req_ready SHALL be all zero in ISSUE, CAPT and RESP.
REQ-007 On accept, the module SHALL register the winner's operand into cvt_operand and its index into rsp_id, and set ptr = (winner+1) mod NREQ.
REQ-008 cvt_enable SHALL be 1 only in ISSUE, for exactly one cycle per accepted request; cvt_operand SHALL be stable throughout ISSUE.
REQ-009 In CAPT, the module SHALL register cvt_result into rsp_result and cvt_fpcsr into rsp_fpcsr.
- The converter latency is one cycle.
REQ-010 In CAPT, flags_sticky SHALL become flags_sticky|cvt_fpcsr.
- If flags_clear is high in the same cycle, flags_sticky SHALL become cvt_fpcsr.
- If flags_clear is high in any other cycle, flags_sticky SHALL become 0.
REQ-011 rsp_valid SHALL be 1 throughout RESP and 0 elsewhere.
- rsp_id, rsp_result and rsp_fpcsr SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-012 op_count SHALL increment on each rsp_valid&rsp_ready and wrap from 0xFFFF to 0x0000.
REQ-013 Timing SHALL be: accept at cycle T; cvt_enable at T+1; rsp_valid earliest at T+3.
- Next accept is no earlier than the cycle after the response handshake.
REQ-014 Requesters SHALL hold req_valid and req_operand until req_ready.
- A requester dropping req_valid before accept is not granted.
REQ-015 The module SHALL apply no transformation to converter data; rsp_result and rsp_fpcsr equal the converter outputs bit-for-bit.

Reset
REQ-016 On reset assertion, at any state, the module SHALL asynchronously force the following; any in-flight operation is discarded without a response:
- state=IDLE, ptr=0
- req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_fpcsr=0
- cvt_enable=0, cvt_operand=0
- flags_sticky=0, busy=0, op_count=0
REQ-017 After reset release, the first grant SHALL go to the lowest-indexed valid requester.

Verification
REQ-018 Single op: req 2 sends 0x3F800000 with rsp_ready=1 -> cvt_enable pulse at T+1; at T+3 rsp_valid=1, rsp_id=2, rsp_result=0x3F80, rsp_fpcsr=0; op_count=1.
REQ-019 NaN flags: 0x7FC00001 -> rsp_result=0x7FC0, rsp_fpcsr=4'b1000, flags_sticky=4'b1000.
- Then 0x7F800000 -> rsp_result=0x7F80, flags_sticky stays 4'b1000.
- flags_clear pulse -> flags_sticky=0.
REQ-020 Round-robin: all four requesters hold valid continuously after reset -> grant order 0,1,2,3,0; req_ready is never multi-hot.
REQ-021 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and payload are held, req_ready stays 0, op_count is unchanged until the handshake.
REQ-022 Reset mid-op: reset asserted during ISSUE -> all outputs are 0 immediately and no rsp_valid follows.
- Next grant after release goes to the lowest valid index.
REQ-023 Wrap: after 65536 handshakes op_count=0x0000.
- flags_clear coincident with a CAPT whose cvt_fpcsr=4'b1000 -> flags_sticky=4'b1000.
